filter_loader: RTL and testbench
================================

// Module: filter_loader
// PURPOSE
//  Upstream feeder for the 9-tap filter shift register in the convolver.
//  - Accepts one 3x3 filter (NUM_TAPS weights) from the weight stream using a valid/ready handshake.
//  - Drives the shift register's serial data input (sr_data) and shift enable (sr_shift).
//  - Signals when the shift register holds a complete filter.
//  - Sits between the weight buffer/DMA read port and the convolver's filter shift register.
// PARAMETERS
//  NUM_TAPS  9            weights per filter; equals shift register depth
//  WID       `WID_FILTER  weight word width
//  CNT_W     4            tap counter width; must satisfy 2**CNT_W > NUM_TAPS
// PORTS
//  clk       in   1         clock, rising edge
//  rst       in   1         synchronous reset, active-high
//  start     in   1         pulse: begin loading a new filter (honoured only in IDLE)
//  abort     in   1         pulse: cancel the load in progress
//  w_data    in   WID       weight word from the weight stream
//  w_valid   in   1         w_data valid
//  w_ready   out  1         loader accepts w_data this cycle
//  sr_data   out  WID       to shift register inp_sr; holds last accepted word
//  sr_shift  out  1         to shift register shifting enable
//  busy      out  1         state != IDLE
//  done      out  1         one-cycle pulse: filter complete in shift register
//  loaded    out  1         level: shift register holds a complete, valid filter
//  tap_cnt   out  CNT_W     number of words accepted in the current load
// BEHAVIOUR
//  Reset (sync, rst=1 at a rising edge):
//   - state=IDLE.
//   - sr_data, sr_shift, done, loaded, tap_cnt all 0; w_ready=0, busy=0.
//   - rst overrides start and abort.
//  States: IDLE, LOAD, FLUSH. State is registered; w_ready=(state==LOAD); busy=(state!=IDLE).
//  IDLE:
//   - start=1 -> LOAD; tap_cnt<=0; loaded<=0.
//   - w_valid is ignored.
//  LOAD:
//   - Accept occurs when w_valid & w_ready. On accept: sr_data<=w_data, tap_cnt<=tap_cnt+1.
//   - The accept on which tap_cnt==NUM_TAPS-1 -> FLUSH.
//   - abort=1 -> IDLE: no done; loaded stays 0; tap_cnt<=0. Abort wins over a simultaneous accept.
//   - start is ignored.
//  FLUSH: one cycle, then -> IDLE; done<=1 and loaded<=1 at that edge. abort is ignored in FLUSH.
//  sr_shift:
//   - Registered. sr_shift<=1 at the edge of each accept, so it is high exactly in the cycle after the accept.
//   - Otherwise sr_shift<=0; sr_data holds its value.
//   - Back-to-back accepts give consecutive sr_shift cycles, 1:1 with accepted words.
//  Latency:
//   - Accepted word reaches the shift register 2 edges after the accept.
//   - done is high in the cycle immediately after the last sr_shift cycle.
//   - Minimum load: start + NUM_TAPS accept cycles + FLUSH = NUM_TAPS+2 cycles to done.
//  Tap ordering: accepted word k (0-based) ends in shift register out_(NUM_TAPS-k).
//   The weight stream therefore sends tap 9 first and tap 1 last.
//  done is a single-cycle pulse. loaded stays 1 until the next accepted start or rst.
//  start in IDLE with loaded=1 clears loaded at the same edge.
//  Widths: tap_cnt never exceeds NUM_TAPS-1 while in LOAD; no wrap-around.
//  Reset mid-LOAD: partial data remains in the shift register but loaded=0; no done is produced.
// STRUCTURE
//  header.vh: `WID_FILTER, `NUM_TAPS (9), state encodings (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2).
//  Single flat module; no sub-modules. Bench instantiates filter_loader -> shift_register9.
// TESTING
//  1 Reset: hold rst 2 cycles -> w_ready, sr_shift, done, loaded, busy, tap_cnt all 0; sr_data=0.
//  2 start, then w_data 1..9 with w_valid continuously high:
//    -> sr_shift high 9 consecutive cycles; done one cycle, right after the last sr_shift;
//    -> shift register out_1=9 ... out_9=1; loaded=1.
//  3 Same stream with w_valid toggling 1,0,1,0:
//    -> exactly 9 sr_shift pulses, each one cycle after an accept; identical final shift register contents.
//  4 abort after 4 accepts (abort and w_valid both high on the 5th word):
//    -> word 5 not accepted; IDLE next cycle; w_ready=0; no done; loaded=0; tap_cnt=0.
//  5 start pulses during LOAD -> ignored (tap_cnt continues).
//    New start with loaded=1 -> loaded=0 next cycle; reload 9 words -> new done.
//  6 rst asserted after 5 accepts -> next cycle IDLE with all outputs 0;
//    a following full load completes normally with done after 11 cycles.

Source files
------------

// File: rtl/filter_loader_pkg.sv
// Shared constants and state encoding for the filter loader that feeds
// the convolver's 9-tap filter shift register.
package filter_loader_pkg;

   localparam int WID_FILTER = 8;
   localparam int NUM_TAPS_DEF = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/filter_loader.sv
// Loads one 3x3 filter from a valid/ready weight stream into the serial
// filter shift register and reports when a complete filter is in place.
module filter_loader
   import filter_loader_pkg::*;
#(
   parameter int NUM_TAPS = NUM_TAPS_DEF,
   parameter int WID      = WID_FILTER,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WID-1:0]   w_data,
   input  logic             w_valid,
   output logic             w_ready,
   output logic [WID-1:0]   sr_data,
   output logic             sr_shift,
   output logic             busy,
   output logic             done,
   output logic             loaded,
   output logic [CNT_W-1:0] tap_cnt
);

   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q,    state_d;
   logic [CNT_W-1:0] tap_cnt_q,  tap_cnt_d;
   logic [WID-1:0]   sr_data_q,  sr_data_d;
   logic             sr_shift_q, sr_shift_d;
   logic             done_q,     done_d;
   logic             loaded_q,   loaded_d;

   // Next-state and registered-output computation for the load sequencer.
   always_comb begin
      state_d    = state_q;
      tap_cnt_d  = tap_cnt_q;
      sr_data_d  = sr_data_q;
      sr_shift_d = 1'b0;
      done_d     = 1'b0;
      loaded_d   = loaded_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               tap_cnt_d = '0;
               loaded_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            // Abort takes priority over a word offered in the same cycle.
            if (abort) begin
               state_d   = IDLE;
               tap_cnt_d = '0;
            end else if (w_valid) begin
               sr_data_d  = w_data;
               sr_shift_d = 1'b1;
               tap_cnt_d  = tap_cnt_q + CNT_ONE;
               if (tap_cnt_q == LAST_TAP) begin
                  state_d = FLUSH;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         FLUSH: begin
            state_d  = IDLE;
            done_d   = 1'b1;
            loaded_d = 1'b1;
         end
         default: begin
            state_d   = IDLE;
            tap_cnt_d = '0;
            loaded_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tap_cnt_q  <= '0;
         sr_data_q  <= '0;
         sr_shift_q <= 1'b0;
         done_q     <= 1'b0;
         loaded_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tap_cnt_q  <= tap_cnt_d;
         sr_data_q  <= sr_data_d;
         sr_shift_q <= sr_shift_d;
         done_q     <= done_d;
         loaded_q   <= loaded_d;
      end
   end

   assign w_ready  = (state_q == LOAD);
   assign busy     = (state_q != IDLE);
   assign sr_data  = sr_data_q;
   assign sr_shift = sr_shift_q;
   assign done     = done_q;
   assign loaded   = loaded_q;
   assign tap_cnt  = tap_cnt_q;

endmodule

// File: tb/tb_filter_loader.sv
// Self-checking bench for filter_loader: a vector table for reset/abort
// behaviour plus scoreboarded full loads into a model 9-deep shift register.
module tb_filter_loader;

   logic       clk = 1'b0;
   logic       rst, start, abort, w_valid;
   logic [7:0] w_data;
   logic       w_ready, sr_shift, busy, done, loaded;
   logic [7:0] sr_data;
   logic [3:0] tap_cnt;

   int total = 0;
   int bad   = 0;

   logic [7:0] sbq[$];
   logic [7:0] sh [1:9];

   always #5 clk = ~clk;

   filter_loader dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .w_data  (w_data),
      .w_valid (w_valid),
      .w_ready (w_ready),
      .sr_data (sr_data),
      .sr_shift(sr_shift),
      .busy    (busy),
      .done    (done),
      .loaded  (loaded),
      .tap_cnt (tap_cnt)
   );

   // stand-in for the convolver's shift_register9: out_1 is sh[1]
   initial for (int j = 1; j <= 9; j++) sh[j] = 8'd0;
   always @(posedge clk) begin
      if (sr_shift === 1'b1) begin
         for (int j = 9; j > 1; j--) sh[j] <= sh[j-1];
         sh[1] <= sr_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst, start, abort, w_valid;
      logic [7:0] w_data;
      logic       e_ready, e_busy, e_shift, e_done, e_loaded;
      logic [3:0] e_cnt;
      logic [7:0] e_data;
   } vec_t;

   vec_t tbl[12];

   task automatic load_filter(input int base, input bit toggle, input bit inj, input bit chk_lat);
      int acc = 0;
      int cyc = 0;
      int shifts = 0;
      bit acc_now, prev_shift, got_done;
      logic [7:0] d;
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1;
      chk("start_ready", w_ready, 1);
      chk("start_busy", busy, 1);
      chk("start_clears_loaded", loaded, 0);
      chk("start_tap_cnt", tap_cnt, 0);
      got_done = 1'b0;
      prev_shift = 1'b0;
      while (!got_done && cyc < 60) begin
         acc_now = 1'b0;
         if (acc < 9 && (!toggle || (cyc % 2) == 1)) begin
            chk("ready_when_offered", w_ready, 1);
            w_valid = 1'b1;
            w_data  = 8'(base + acc + 1);
            sbq.push_back(w_data);
            acc_now = 1'b1;
            acc++;
         end else begin
            w_valid = 1'b0;
            w_data  = 8'hEE;
         end
         start = inj && acc_now && (acc % 2 == 0);
         step();
         start = 1'b0;
         cyc++;
         chk("shift_follows_accept", sr_shift, acc_now);
         if (sr_shift === 1'b1) begin
            shifts++;
            if (sbq.size() == 0) begin
               chk("scoreboard_empty", 1, 0);
            end else begin
               d = sbq.pop_front();
               chk("sr_data", sr_data, d);
            end
         end
         if (acc_now) chk("tap_cnt", tap_cnt, acc);
         if (done === 1'b1) begin
            got_done = 1'b1;
            chk("done_after_last_shift", prev_shift, 1);
         end
         prev_shift = sr_shift;
      end
      w_valid = 1'b0;
      chk("done_seen", got_done, 1);
      chk("shift_count", shifts, 9);
      chk("loaded_at_done", loaded, 1);
      chk("idle_at_done", busy, 0);
      chk("not_ready_at_done", w_ready, 0);
      if (chk_lat) chk("latency", cyc, 11);
      for (int j = 1; j <= 9; j++) chk($sformatf("out_%0d", j), sh[j], 8'(base + 10 - j));
      step();
      chk("done_single_pulse", done, 0);
      chk("loaded_holds", loaded, 1);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; w_valid = 1'b0; w_data = 8'd0;
      //          rst   start abort wv    data    rdy   busy  shift done  ld    cnt   sr_data
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd11};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 8'd12};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 8'd12};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 8'd13};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 8'd14};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd14};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd14};

      // reset, idle ignores valid/abort, start ignored in LOAD, abort beats accept
      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
         w_valid = tbl[i].w_valid; w_data = tbl[i].w_data;
         step();
         chk($sformatf("v%0d_w_ready", i), w_ready, tbl[i].e_ready);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("v%0d_sr_shift", i), sr_shift, tbl[i].e_shift);
         chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
         chk($sformatf("v%0d_loaded", i), loaded, tbl[i].e_loaded);
         chk($sformatf("v%0d_tap_cnt", i), tap_cnt, tbl[i].e_cnt);
         chk($sformatf("v%0d_sr_data", i), sr_data, tbl[i].e_data);
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0; w_valid = 1'b0;

      load_filter(0, 1'b0, 1'b0, 1'b1);
      load_filter(0, 1'b1, 1'b0, 1'b0);
      load_filter(40, 1'b0, 1'b1, 1'b1);
      load_filter(20, 1'b0, 1'b0, 1'b1);

      // reset in the middle of a load
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w_valid = 1'b1;
         w_data  = 8'(50 + i);
         step();
      end
      chk("pre_rst_tap_cnt", tap_cnt, 5);
      w_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_w_ready", w_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sr_shift", sr_shift, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_tap_cnt", tap_cnt, 0);
      chk("rst_sr_data", sr_data, 0);
      step();
      chk("rst_no_done", done, 0);
      chk("rst_still_idle", busy, 0);
      load_filter(60, 1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
